// File: rtl/risc8_core.sv
// 8-bit single-cycle RISC core: 16-bit instructions, 4x8 register file, external I/D memories.
// Build option HALT_INSTR_EN turns opcode 4'hF into HALT and adds the halted output.
module risc8_regfile (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] ra_addr,
   input  logic [1:0] rb_addr,
   output logic [7:0] ra_data,
   output logic [7:0] rb_data,
   input  logic       wr_en,
   input  logic [1:0] wr_addr,
   input  logic [7:0] wr_data
);
   logic [7:0] registers [0:3];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) registers[i] <= 8'h00;
      end else if (wr_en && (wr_addr != 2'd0)) begin
         registers[wr_addr] <= wr_data;
      end
   end

   assign ra_data = (ra_addr == 2'd0) ? 8'h00 : registers[ra_addr];
   assign rb_data = (rb_addr == 2'd0) ? 8'h00 : registers[rb_addr];
endmodule

module risc8_core #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   output logic [7:0]  instr_addr,
   input  logic [15:0] instr_data,
   output logic [7:0]  data_addr,
   output logic        data_write,
   output logic [7:0]  data_out,
   input  logic [7:0]  data_in
`ifdef HALT_INSTR_EN
   ,
   output logic        halted
`endif
);
   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LW    = 4'h2;
   localparam logic [3:0] OP_SW    = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;

   logic [7:0] pc_q, pc_d;
   logic       halted_q, halted_d;

   logic [3:0] opcode;
   logic [7:0] imm8;
   logic [1:0] ra_addr, rb_addr;
   logic [7:0] ra_data, rb_data;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic [7:0] alu_res;
   logic       is_halt;

   assign opcode = instr_data[15:12];
   assign imm8   = instr_data[7:0];

   // R-type and I-type place the source fields differently.
   assign ra_addr = (opcode == OP_RTYPE) ? instr_data[7:6] : instr_data[11:10];
   assign rb_addr = (opcode == OP_RTYPE) ? instr_data[5:4] : instr_data[9:8];

   risc8_regfile reg_file (
      .clk     (clk),
      .reset   (reset),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .ra_data (ra_data),
      .rb_data (rb_data),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

`ifdef HALT_INSTR_EN
   assign is_halt = (opcode == 4'hF);
   assign halted  = halted_q;
`else
   assign is_halt = 1'b0;
`endif

   always_comb begin
      alu_res = 8'h00;
      unique case (instr_data[1:0])
         2'b00: alu_res = ra_data + rb_data;
         2'b01: alu_res = ra_data - rb_data;
         2'b10: alu_res = ra_data & rb_data;
         2'b11: alu_res = ra_data | rb_data;
         default: alu_res = 8'h00;
      endcase
   end

   assign data_addr  = ra_data + imm8;
   assign data_out   = rb_data;
   assign data_write = reset && !halted_q && (opcode == OP_SW);

   always_comb begin
      wr_en   = 1'b0;
      wr_addr = instr_data[9:8];
      wr_data = 8'h00;
      case (opcode)
         OP_RTYPE: begin
            wr_en   = 1'b1;
            wr_addr = instr_data[3:2];
            wr_data = alu_res;
         end
         OP_ADDI: begin
            wr_en   = 1'b1;
            wr_data = ra_data + imm8;
         end
         OP_LW: begin
            wr_en   = 1'b1;
            wr_data = data_in;
         end
         default: ;
      endcase
      if (halted_q) wr_en = 1'b0;
   end

   always_comb begin
      pc_d     = pc_q + 8'd1;
      halted_d = halted_q;
      if (halted_q) begin
         pc_d = pc_q;
      end else if (is_halt) begin
         pc_d     = pc_q;
         halted_d = 1'b1;
      end else if (opcode == OP_BEQ) begin
         if (ra_data == rb_data) pc_d = pc_q + 8'd1 + imm8;
      end else if (opcode == OP_JMP) begin
         pc_d = imm8;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign instr_addr = pc_q;
endmodule

// File: tb/tb_risc8_core.sv
// Directed bench for risc8_core; register contents are observed through data_out by
// presenting an un-clocked SW of the register of interest.
`timescale 1ns/1ps
module tb_risc8_core;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  instr_addr;
   logic [15:0] instr_data = 16'h3100;
   logic [7:0]  data_addr;
   logic        data_write;
   logic [7:0]  data_out;
   logic [7:0]  data_in = 8'h00;
`ifdef HALT_INSTR_EN
   logic        halted;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   risc8_core #(.RESET_PC(8'h00)) dut (
      .clk        (clk),
      .reset      (reset),
      .instr_addr (instr_addr),
      .instr_data (instr_data),
      .data_addr  (data_addr),
      .data_write (data_write),
      .data_out   (data_out),
      .data_in    (data_in)
`ifdef HALT_INSTR_EN
      ,
      .halted     (halted)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
      end
      $display("check %-14s observed %02h expected %02h", tag, obs, exp);
   endtask

   // Present an instruction on the falling edge so it settles before the next rising edge.
   task automatic present(input logic [15:0] ins, input logic [7:0] din);
      @(negedge clk);
      instr_data = ins;
      data_in    = din;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input int n, input logic [7:0] exp);
      instr_data = 16'h3000 | (16'(n) << 8);
      #0.2;
      chk($sformatf("R%0d", n), data_out, exp);
   endtask

   initial begin
      // Reset held across three edges with a SW presented: strobe must stay low.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_pc", instr_addr, 8'h00);
      chk("rst_dwr", {7'b0, data_write}, 8'h00);
      peek(1, 8'h00);
      peek(2, 8'h00);
      peek(3, 8'h00);

      // Load/add/store program
      instr_data = 16'h2108;
      data_in    = 8'h0A;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("lw1_addr", data_addr, 8'h08);
      chk("lw1_dwr", {7'b0, data_write}, 8'h00);
      tick();
      present(16'h2209, 8'h01);
      chk("lw2_addr", data_addr, 8'h09);
      tick();
      present(16'h006C, 8'h00);
      tick();
      present(16'h330A, 8'h00);
      chk("sw_addr", data_addr, 8'h0A);
      chk("sw_data", data_out, 8'h0B);
      chk("sw_dwr", {7'b0, data_write}, 8'h01);
      tick();
      chk("prog_pc", instr_addr, 8'h04);
      peek(1, 8'h0A);
      peek(2, 8'h01);
      peek(3, 8'h0B);

      // R0 is hardwired to zero
      present(16'h1055, 8'h00);
      tick();
      present(16'h0004, 8'h00);
      tick();
      peek(0, 8'h00);
      peek(1, 8'h00);
      chk("r0_pc", instr_addr, 8'h06);

      // Arithmetic wrap
      present(16'h11FF, 8'h00);
      tick();
      present(16'h1502, 8'h00);
      tick();
      peek(1, 8'h01);
      present(16'h1200, 8'h00);
      tick();
      present(16'h009D, 8'h00);
      tick();
      peek(3, 8'hFF);
      chk("wrap_pc", instr_addr, 8'h0A);
      // ADD R1,R1,R1 reads the old value
      present(16'h0054, 8'h00);
      tick();
      peek(1, 8'h02);

      // Branch, jump, PC wrap
      present(16'h5005, 8'h00);
      tick();
      chk("jmp5_pc", instr_addr, 8'h05);
      present(16'h4002, 8'h00);
      tick();
      chk("beq_tk_pc", instr_addr, 8'h08);
      present(16'h4102, 8'h00);
      tick();
      chk("beq_nt_pc", instr_addr, 8'h09);
      present(16'h40FD, 8'h00);
      tick();
      chk("beq_neg_pc", instr_addr, 8'h07);
      present(16'h50FF, 8'h00);
      tick();
      chk("jmpff_pc", instr_addr, 8'hFF);
      present(16'h7000, 8'h00);
      chk("nop_dwr", {7'b0, data_write}, 8'h00);
      tick();
      chk("pcwrap_pc", instr_addr, 8'h00);
      present(16'h7000, 8'h00);
      tick();
      chk("nop_pc", instr_addr, 8'h01);

      // Asynchronous reset in the middle of an ADDI aborts it
      present(16'h1133, 8'h00);
      #1;
      reset = 1'b0;
      #1;
      chk("mrst_pc", instr_addr, 8'h00);
      peek(1, 8'h00);
      instr_data = 16'h1133;
      tick();
      chk("mrst_hold_pc", instr_addr, 8'h00);
      peek(1, 8'h00);
      instr_data = 16'h7000;
      @(negedge clk);
      reset = 1'b1;
      #1;
      tick();
      chk("mrst_rel_pc", instr_addr, 8'h01);

      // Opcode F
      present(16'h5003, 8'h00);
      tick();
      present(16'hF000, 8'h00);
      tick();
`ifdef HALT_INSTR_EN
      for (int i = 0; i < 5; i++) begin
         chk("halt_pc", instr_addr, 8'h03);
         chk("halt_flag", {7'b0, halted}, 8'h01);
         present(16'h1177, 8'h00);
         tick();
      end
      chk("halt_pc_end", instr_addr, 8'h03);
      peek(1, 8'h00);
      reset = 1'b0;
      #1;
      chk("halt_rst_flag", {7'b0, halted}, 8'h00);
      chk("halt_rst_pc", instr_addr, 8'h00);
`else
      chk("opf_nop_pc", instr_addr, 8'h04);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
